wb_trace_checker: RTL and testbench

Synthesizable writeback-trace checker for the RISC-V core's difftest flow. It compares each committed register write from up to `NUM_PORTS` writeback channels against an in-order reference stream, which is buffered in an internal FIFO. It latches the first divergence and counts matched entries. It sits beside `soc_lite_top`, tapping the `debug_wb_*` signals, so multi-issue cores and FPGA runs can be checked without a simulator-side file compare.

---
 rtl/wb_trace_checker.sv | 208 ++++++++++++++++++++
 tb/tb_wb_trace_checker.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_checker.sv
// Writeback-trace checker: matches committed register writes from NUM_PORTS channels
// against an in-order reference FIFO. Optional unchanged-write filter: WB_TRACE_CHK_SKIP_EQ_EN.
module wb_trace_checker #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned XLEN      = 64,
  parameter int unsigned PC_W      = 64,
  parameter int unsigned REF_DEPTH = 16
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              chk_en,
  input  logic [31:0]                                       target_cnt,
  input  logic [NUM_PORTS*PC_W-1:0]                         debug_wb_pc,
  input  logic [NUM_PORTS*XLEN/8-1:0]                       debug_wb_rf_wen,
  input  logic [NUM_PORTS*5-1:0]                            debug_wb_rf_wnum,
  input  logic [NUM_PORTS*XLEN-1:0]                         debug_wb_rf_wdata,
  input  logic                                              ref_valid,
  output logic                                              ref_ready,
  input  logic [PC_W-1:0]                                   ref_pc,
  input  logic [4:0]                                        ref_wnum,
  input  logic [XLEN-1:0]                                   ref_wdata,
  output logic                                              err,
  output logic [1:0]                                        err_kind,
  output logic [((NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1)-1:0] err_port,
  output logic [PC_W-1:0]                                   err_pc,
  output logic [PC_W-1:0]                                   err_exp_pc,
  output logic [4:0]                                        err_wnum,
  output logic [4:0]                                        err_exp_wnum,
  output logic [XLEN-1:0]                                   err_wdata,
  output logic [XLEN-1:0]                                   err_exp_wdata,
  output logic [31:0]                                       match_cnt,
  output logic                                              done
);

  localparam int unsigned BE_W   = XLEN / 8;
  localparam int unsigned PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned PTR_W  = $clog2(REF_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  logic [PC_W-1:0]   fifo_pc    [REF_DEPTH];
  logic [4:0]        fifo_wnum  [REF_DEPTH];
  logic [XLEN-1:0]   fifo_wdata [REF_DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic              push;

  logic [XLEN-1:0]      mdata [NUM_PORTS];
  logic [NUM_PORTS-1:0] matched;
  logic [CNT_W-1:0]     pop_n;
  logic                 stop;
  logic                 qual;
  logic [4:0]           wn;
  logic [PTR_W-1:0]     idx;
  logic                 fail;
  logic [1:0]           fail_kind;
  logic [PORT_W-1:0]    fail_port;
  logic [PC_W-1:0]      fail_pc;
  logic [PC_W-1:0]      fail_exp_pc;
  logic [4:0]           fail_wnum;
  logic [4:0]           fail_exp_wnum;
  logic [XLEN-1:0]      fail_wdata;
  logic [XLEN-1:0]      fail_exp_wdata;
  logic [31:0]          match_nxt;
  logic                 err_nxt;

`ifdef WB_TRACE_CHK_SKIP_EQ_EN
  logic [XLEN-1:0] shadow [32];
  logic [XLEN-1:0] seen;
`endif

  assign push      = ref_valid && ref_ready;
  assign count_nxt = count + CNT_W'(push) - pop_n;
  assign match_nxt = match_cnt + 32'(pop_n);
  assign err_nxt   = err | fail;

  // Byte-enable masking of commit data
  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++) begin
      for (int k = 0; k < BE_W; k++) begin
        mdata[j][k*8 +: 8] = debug_wb_rf_wen[j*BE_W + k] ? debug_wb_rf_wdata[j*XLEN + k*8 +: 8] : 8'h00;
      end
    end
  end

  // Walk ports oldest-first; the k-th qualifying port compares against entry head+k
  always_comb begin
    matched        = '0;
    pop_n          = '0;
    stop           = err;
    qual           = 1'b0;
    wn             = '0;
    idx            = head;
    fail           = 1'b0;
    fail_kind      = 2'b00;
    fail_port      = '0;
    fail_pc        = '0;
    fail_exp_pc    = '0;
    fail_wnum      = '0;
    fail_exp_wnum  = '0;
    fail_wdata     = '0;
    fail_exp_wdata = '0;
`ifdef WB_TRACE_CHK_SKIP_EQ_EN
    seen           = '0;
`endif
    for (int j = 0; j < NUM_PORTS; j++) begin
      wn = debug_wb_rf_wnum[j*5 +: 5];
`ifdef WB_TRACE_CHK_SKIP_EQ_EN
      seen = shadow[wn];
      for (int i = 0; i < j; i++) begin
        if (matched[i] && (debug_wb_rf_wnum[i*5 +: 5] == wn)) seen = mdata[i];
      end
      qual = chk_en && (|debug_wb_rf_wen[j*BE_W +: BE_W]) && (wn != 5'd0) && (mdata[j] != seen);
`else
      qual = chk_en && (|debug_wb_rf_wen[j*BE_W +: BE_W]) && (wn != 5'd0);
`endif
      idx = head + PTR_W'(pop_n);
      if (!stop && qual) begin
        if (pop_n >= count) begin
          stop       = 1'b1;
          fail       = 1'b1;
          fail_kind  = 2'b10;
          fail_port  = PORT_W'(j);
          fail_pc    = debug_wb_pc[j*PC_W +: PC_W];
          fail_wnum  = wn;
          fail_wdata = mdata[j];
        end else if ((fifo_pc[idx] == debug_wb_pc[j*PC_W +: PC_W]) &&
                     (fifo_wnum[idx] == wn) && (fifo_wdata[idx] == mdata[j])) begin
          matched[j] = 1'b1;
          pop_n      = pop_n + CNT_W'(1);
        end else begin
          stop           = 1'b1;
          fail           = 1'b1;
          fail_kind      = 2'b01;
          fail_port      = PORT_W'(j);
          fail_pc        = debug_wb_pc[j*PC_W +: PC_W];
          fail_wnum      = wn;
          fail_wdata     = mdata[j];
          fail_exp_pc    = fifo_pc[idx];
          fail_exp_wnum  = fifo_wnum[idx];
          fail_exp_wdata = fifo_wdata[idx];
        end
      end
    end
  end

  // Reference storage has no reset; occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[tail]    <= ref_pc;
      fifo_wnum[tail]  <= ref_wnum;
      fifo_wdata[tail] <= ref_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      ref_ready     <= 1'b1;
      err           <= 1'b0;
      err_kind      <= 2'b00;
      err_port      <= '0;
      err_pc        <= '0;
      err_exp_pc    <= '0;
      err_wnum      <= '0;
      err_exp_wnum  <= '0;
      err_wdata     <= '0;
      err_exp_wdata <= '0;
      match_cnt     <= '0;
      done          <= 1'b0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      head      <= head + PTR_W'(pop_n);
      count     <= count_nxt;
      ref_ready <= (count_nxt != CNT_W'(REF_DEPTH));
      match_cnt <= match_nxt;
      err       <= err_nxt;
      done      <= (target_cnt != 32'd0) && (match_nxt >= target_cnt) && !err_nxt;
      if (fail) begin
        err_kind      <= fail_kind;
        err_port      <= fail_port;
        err_pc        <= fail_pc;
        err_exp_pc    <= fail_exp_pc;
        err_wnum      <= fail_wnum;
        err_exp_wnum  <= fail_exp_wnum;
        err_wdata     <= fail_wdata;
        err_exp_wdata <= fail_exp_wdata;
      end
    end
  end

`ifdef WB_TRACE_CHK_SKIP_EQ_EN
  // Shadow register file; later ports overwrite earlier ones for the same register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) shadow[r] <= '0;
    end else begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (matched[j]) shadow[debug_wb_rf_wnum[j*5 +: 5]] <= mdata[j];
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_trace_checker.sv
// Randomized bench for wb_trace_checker against a queue-based reference model.
module tb_wb_trace_checker;

  localparam int NP    = 2;
  localparam int XL    = 64;
  localparam int PW    = 64;
  localparam int DEPTH = 16;
  localparam int BE    = XL / 8;
`ifdef WB_TRACE_CHK_SKIP_EQ_EN
  localparam int SKIP = 1;
`else
  localparam int SKIP = 0;
`endif

  typedef struct {
    logic [63:0] pc;
    logic [4:0]  wnum;
    logic [63:0] data;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          chk_en;
  logic [31:0]   target_cnt;
  logic [PW-1:0] c_pc    [NP];
  logic [BE-1:0] c_wen   [NP];
  logic [4:0]    c_wnum  [NP];
  logic [XL-1:0] c_wdata [NP];
  logic [NP*PW-1:0] debug_wb_pc;
  logic [NP*BE-1:0] debug_wb_rf_wen;
  logic [NP*5-1:0]  debug_wb_rf_wnum;
  logic [NP*XL-1:0] debug_wb_rf_wdata;
  logic          ref_valid;
  logic          ref_ready;
  logic [PW-1:0] ref_pc;
  logic [4:0]    ref_wnum;
  logic [XL-1:0] ref_wdata;
  logic          err;
  logic [1:0]    err_kind;
  logic [0:0]    err_port;
  logic [PW-1:0] err_pc, err_exp_pc;
  logic [4:0]    err_wnum, err_exp_wnum;
  logic [XL-1:0] err_wdata, err_exp_wdata;
  logic [31:0]   match_cnt;
  logic          done;

  always_comb begin
    for (int j = 0; j < NP; j++) begin
      debug_wb_pc[j*PW +: PW]       = c_pc[j];
      debug_wb_rf_wen[j*BE +: BE]   = c_wen[j];
      debug_wb_rf_wnum[j*5 +: 5]    = c_wnum[j];
      debug_wb_rf_wdata[j*XL +: XL] = c_wdata[j];
    end
  end

  wb_trace_checker #(.NUM_PORTS(NP), .XLEN(XL), .PC_W(PW), .REF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .chk_en(chk_en), .target_cnt(target_cnt),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .ref_valid(ref_valid), .ref_ready(ref_ready), .ref_pc(ref_pc),
    .ref_wnum(ref_wnum), .ref_wdata(ref_wdata),
    .err(err), .err_kind(err_kind), .err_port(err_port),
    .err_pc(err_pc), .err_exp_pc(err_exp_pc),
    .err_wnum(err_wnum), .err_exp_wnum(err_exp_wnum),
    .err_wdata(err_wdata), .err_exp_wdata(err_exp_wdata),
    .match_cnt(match_cnt), .done(done)
  );

  // Reference model state
  ent_t        ref_q[$];
  ent_t        avail_q[$];
  logic [63:0] m_shadow [32];
  logic        m_err, m_done, m_ready;
  logic [1:0]  m_kind;
  logic [0:0]  m_port;
  logic [63:0] m_pc, m_epc, m_wd, m_ewd;
  logic [4:0]  m_wn, m_ewn;
  int unsigned m_cnt;

  int n_total = 0;
  int n_bad   = 0;
  int pushed_n = 0;
  int unsigned exp_n;
  logic [63:0] gen_pc = 64'hA000_0000;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mask_data(input logic [BE-1:0] wen, input logic [63:0] d);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < BE; k++) if (wen[k]) r[k*8 +: 8] = d[k*8 +: 8];
    return r;
  endfunction

  task automatic record_err(input logic [1:0] kind, input int j, input logic [63:0] md,
                            input logic [63:0] epc, input logic [4:0] ewn, input logic [63:0] ewd);
    m_err = 1'b1; m_kind = kind; m_port = 1'(j);
    m_pc = c_pc[j]; m_wn = c_wnum[j]; m_wd = md;
    m_epc = epc; m_ewn = ewn; m_ewd = ewd;
  endtask

  // Applies one clock edge worth of behaviour to the model, from the inputs now driven
  task automatic model_edge();
    int used;
    logic [63:0] md;
    bit q;
    bit push_ok;
    if (rst) begin
      ref_q.delete();
      for (int r = 0; r < 32; r++) m_shadow[r] = '0;
      m_err = 0; m_kind = 0; m_port = 0; m_pc = 0; m_epc = 0;
      m_wn = 0; m_ewn = 0; m_wd = 0; m_ewd = 0;
      m_cnt = 0; m_done = 0; m_ready = 1;
      return;
    end
    push_ok = ref_valid && m_ready;
    used = 0;
    if (!m_err && chk_en) begin
      for (int j = 0; j < NP; j++) begin
        md = mask_data(c_wen[j], c_wdata[j]);
        q = (c_wen[j] != '0) && (c_wnum[j] != 5'd0);
        if (SKIP != 0 && md == m_shadow[c_wnum[j]]) q = 0;
        if (q) begin
          if (used >= ref_q.size()) begin
            record_err(2'b10, j, md, '0, '0, '0);
            break;
          end else if (ref_q[used].pc == c_pc[j] && ref_q[used].wnum == c_wnum[j] &&
                       ref_q[used].data == md) begin
            m_shadow[c_wnum[j]] = md;
            used++;
            m_cnt++;
          end else begin
            record_err(2'b01, j, md, ref_q[used].pc, ref_q[used].wnum, ref_q[used].data);
            break;
          end
        end
      end
      repeat (used) void'(ref_q.pop_front());
    end
    if (push_ok) ref_q.push_back('{ref_pc, ref_wnum, ref_wdata});
    m_ready = (ref_q.size() != DEPTH);
    m_done  = (target_cnt != 0) && (m_cnt >= target_cnt) && !m_err;
  endtask

  task automatic compare_all();
    check("ref_ready", ref_ready, m_ready);
    check("err", err, m_err);
    check("err_kind", err_kind, m_kind);
    check("err_port", err_port, m_port);
    check("err_pc", err_pc, m_pc);
    check("err_exp_pc", err_exp_pc, m_epc);
    check("err_wnum", err_wnum, m_wn);
    check("err_exp_wnum", err_exp_wnum, m_ewn);
    check("err_wdata", err_wdata, m_wd);
    check("err_exp_wdata", err_exp_wdata, m_ewd);
    check("match_cnt", match_cnt, 64'(m_cnt));
    check("done", done, m_done);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_ports();
    for (int j = 0; j < NP; j++) begin
      c_pc[j] = '0; c_wen[j] = '0; c_wnum[j] = '0; c_wdata[j] = '0;
    end
  endtask

  task automatic set_port(input int j, input logic [63:0] pc, input logic [BE-1:0] wen,
                          input logic [4:0] wn, input logic [63:0] d);
    c_pc[j] = pc; c_wen[j] = wen; c_wnum[j] = wn; c_wdata[j] = d;
  endtask

  task automatic push_ref(input logic [63:0] pc, input logic [4:0] wn, input logic [63:0] d);
    ref_valid = 1; ref_pc = pc; ref_wnum = wn; ref_wdata = d;
    step();
    ref_valid = 0;
  endtask

  // One cycle of random traffic: commits drawn in order from already-accepted references
  task automatic drive_cycle(input bit do_push, input int commit_pct, input bit corrupt);
    int k;
    int last_j;
    bit push_ok;
    bit consume_ok;
    logic [BE-1:0] w;
    ent_t e;
    k = 0;
    last_j = -1;
    for (int j = 0; j < NP; j++) begin
      c_pc[j] = {$urandom, $urandom};
      c_wdata[j] = {$urandom, $urandom};
      if ($urandom_range(1) == 0) begin
        c_wen[j] = '0; c_wnum[j] = 5'($urandom_range(31));
      end else begin
        c_wen[j] = BE'($urandom_range(255)); c_wnum[j] = 5'd0;
      end
      if ($urandom_range(99) < commit_pct && k < avail_q.size()) begin
        e = avail_q[k];
        w = (e.data[63:8] == '0) ? 8'h01 : 8'hFF;
        c_pc[j] = e.pc; c_wnum[j] = e.wnum; c_wen[j] = w;
        c_wdata[j] = (w == 8'hFF) ? e.data : {$urandom, $urandom_range(255) << 8} | e.data;
        c_wdata[j][7:0] = e.data[7:0];
        k++;
        last_j = j;
      end
    end
    if (corrupt && last_j >= 0) c_wdata[last_j][0] = ~c_wdata[last_j][0];
    ref_valid = do_push;
    ref_pc    = gen_pc;
    ref_wnum  = 5'($urandom_range(31, 1));
    ref_wdata = ($urandom_range(9) == 0) ? 64'($urandom_range(255, 1)) : {$urandom, $urandom};
    push_ok    = do_push && m_ready && !rst;
    consume_ok = chk_en && !m_err && !rst;
    step();
    if (rst) avail_q.delete();
    else begin
      if (consume_ok) repeat (k) void'(avail_q.pop_front());
      if (push_ok) begin
        avail_q.push_back('{ref_pc, ref_wnum, ref_wdata});
        pushed_n++;
      end
    end
    gen_pc = gen_pc + 64'd4;
    ref_valid = 0;
  endtask

  initial begin
    rst = 1; chk_en = 1; target_cnt = 32'd3;
    ref_valid = 0; ref_pc = '0; ref_wnum = '0; ref_wdata = '0;
    idle_ports();
    step();
    step();
    rst = 0;
    check("rst_cnt", match_cnt, 0);
    check("rst_ready", ref_ready, 1);
    check("rst_err", err, 0);

    // Single port match, then a repeated unchanged write
    push_ref(64'h8000_0000, 5'd1, 64'h5);
    set_port(0, 64'h8000_0000, 8'hFF, 5'd1, 64'h5);
    step();
    idle_ports();
    check("single_cnt", match_cnt, 1);
    check("single_err", err, 0);
    if (SKIP == 0) push_ref(64'h8000_0004, 5'd1, 64'h5);
    set_port(0, 64'h8000_0004, 8'hFF, 5'd1, 64'h5);
    step();
    idle_ports();
    exp_n = 32'(2 - SKIP);
    check("repeat_cnt", match_cnt, 64'(exp_n));
    check("pre_done", done, 0);

    // Dual port, different registers
    push_ref(64'h8000_0008, 5'd2, 64'h11);
    push_ref(64'h8000_000C, 5'd3, 64'h22);
    set_port(0, 64'h8000_0008, 8'hFF, 5'd2, 64'h11);
    set_port(1, 64'h8000_000C, 8'hFF, 5'd3, 64'h22);
    step();
    idle_ports();
    exp_n += 2;
    check("dual_cnt", match_cnt, 64'(exp_n));
    check("dual_ready", ref_ready, 1);

    // Dual port, same register and value: second write forwarded and filtered
    push_ref(64'h8000_0010, 5'd2, 64'h7);
    if (SKIP == 0) push_ref(64'h8000_0014, 5'd2, 64'h7);
    set_port(0, 64'h8000_0010, 8'hFF, 5'd2, 64'h7);
    set_port(1, 64'h8000_0014, 8'hFF, 5'd2, 64'h7);
    step();
    idle_ports();
    exp_n += 32'(2 - SKIP);
    check("fwd_cnt", match_cnt, 64'(exp_n));
    check("done_hit", done, 1);

    // Byte-masked commit data
    push_ref(64'h8000_0018, 5'd4, 64'h0000_0000_1234_5678);
    set_port(0, 64'h8000_0018, 8'h0F, 5'd4, 64'hFFFF_FFFF_1234_5678);
    step();
    idle_ports();
    exp_n += 1;
    check("mask_cnt", match_cnt, 64'(exp_n));
    check("mask_err", err, 0);

    // Fill the FIFO, then push and pop concurrently, then drain
    pushed_n = 0;
    repeat (17) drive_cycle(1'b1, 0, 1'b0);
    check("full_ready", ref_ready, 0);
    repeat (40) drive_cycle(1'b1, 100, 1'b0);
    repeat (20) drive_cycle(1'b0, 100, 1'b0);
    idle_ports();
    exp_n += 32'(pushed_n);
    check("drain_cnt", match_cnt, 64'(exp_n));
    check("drain_ready", ref_ready, 1);

    // Mismatch on port 1; port 0 still counts
    push_ref(64'h9000_0000, 5'd5, 64'h1);
    push_ref(64'h9000_0004, 5'd6, 64'h9);
    set_port(0, 64'h9000_0000, 8'hFF, 5'd5, 64'h1);
    set_port(1, 64'h9000_0004, 8'hFF, 5'd6, 64'hA);
    step();
    idle_ports();
    exp_n += 1;
    check("mm_err", err, 1);
    check("mm_kind", err_kind, 2'b01);
    check("mm_port", err_port, 1);
    check("mm_exp_wdata", err_exp_wdata, 64'h9);
    check("mm_wdata", err_wdata, 64'hA);
    check("mm_cnt", match_cnt, 64'(exp_n));
    push_ref(64'h9000_0008, 5'd7, 64'h3);
    set_port(0, 64'h9000_0004, 8'hFF, 5'd6, 64'h9);
    step();
    idle_ports();
    check("mm_hold_cnt", match_cnt, 64'(exp_n));
    check("mm_hold_wdata", err_wdata, 64'hA);

    // Mid-run reset
    rst = 1;
    step();
    rst = 0;
    avail_q.delete();
    check("rst2_err", err, 0);
    check("rst2_kind", err_kind, 0);
    check("rst2_cnt", match_cnt, 0);
    check("rst2_wdata", err_wdata, 0);
    check("rst2_ready", ref_ready, 1);
    check("rst2_done", done, 0);

    // Starvation on an empty FIFO
    set_port(0, 64'h8000_0010, 8'hFF, 5'd7, 64'h33);
    step();
    idle_ports();
    check("starve_kind", err_kind, 2'b10);
    check("starve_pc", err_pc, 64'h8000_0010);
    check("starve_exp_pc", err_exp_pc, 0);
    check("starve_exp_wnum", err_exp_wnum, 0);
    check("starve_exp_wdata", err_exp_wdata, 0);
    rst = 1;
    step();
    rst = 0;
    avail_q.delete();

    // Random traffic with occasional corruption, chk_en drops and resets
    for (int c = 0; c < 3000; c++) begin
      chk_en = ($urandom_range(19) != 0);
      rst = (m_err && $urandom_range(3) == 0) || ($urandom_range(499) == 0);
      if (rst) target_cnt = 32'($urandom_range(40));
      drive_cycle($urandom_range(3) != 0, 60, $urandom_range(299) == 0);
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
